// File: rtl/bus_pkg.sv
// Shared types and helpers for the soc_bus_arbiter codebase slice.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } bus_state_e;

  localparam int BUS_DW = 32;
  localparam int BUS_AW = 32;

  function automatic int be_width(input int dw);
    return dw / 8;
  endfunction

  // Index width for n items; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Request arbiter: round-robin with a rotating pointer, or a fixed
// lowest-index-wins priority encoder when BUS_FIXED_PRIO_EN is defined.
module rr_arbiter
  import bus_pkg::*;
#(
  parameter int N = 2,
  localparam int PW = clog2_min1(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

`ifdef BUS_FIXED_PRIO_EN

  logic unused_ok;
  assign unused_ok = ^{clk, rstn, advance};

  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = PW'(i);
      end
    end
  end

`else

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            cand;

  // Search starts at the pointer and wraps; first requester found wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr_q) + i) % N;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = PW'(cand);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      if (int'(idx) == N - 1) ptr_d = '0;
      else                    ptr_d = idx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

`endif

endmodule

// File: rtl/soc_bus_arbiter.sv
// N-master / M-slave shared bus: decoded slave select, one outstanding
// transaction, registered response. BUS_FIXED_PRIO_EN selects fixed priority.
module soc_bus_arbiter
  import bus_pkg::*;
#(
  parameter int             NUM_M    = 2,
  parameter int             NUM_S    = 3,
  parameter int             DW       = BUS_DW,
  parameter int             AW       = BUS_AW,
  parameter int             SEL_LSB  = 28,
  parameter logic [DW-1:0]  ERR_DATA = '0,
  localparam int            BW       = be_width(DW),
  localparam int            PW       = clog2_min1(NUM_M),
  localparam int            SLW      = AW - SEL_LSB
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_M-1:0]      m_req,
  input  logic [NUM_M-1:0]      m_we,
  input  logic [NUM_M*AW-1:0]   m_addr,
  input  logic [NUM_M*DW-1:0]   m_wdata,
  input  logic [NUM_M*BW-1:0]   m_be,
  output logic [NUM_M-1:0]      m_gnt,
  output logic [NUM_M-1:0]      m_rvalid,
  output logic [DW-1:0]         m_rdata,
  output logic                  m_err,
  output logic [NUM_S-1:0]      s_req,
  output logic                  s_we,
  output logic [AW-1:0]         s_addr,
  output logic [DW-1:0]         s_wdata,
  output logic [BW-1:0]         s_be,
  input  logic [NUM_S*DW-1:0]   s_rdata
);

  bus_state_e state_q, state_d;

  logic [PW-1:0]    win_q, win_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [BW-1:0]    be_q, be_d;

  logic [NUM_M-1:0] gnt_q, gnt_d;
  logic [NUM_M-1:0] rvalid_q, rvalid_d;
  logic             merr_q, merr_d;
  logic [NUM_S-1:0] s_req_q, s_req_d;
  logic             s_we_q, s_we_d;
  logic [AW-1:0]    s_addr_q, s_addr_d;
  logic [DW-1:0]    s_wdata_q, s_wdata_d;
  logic [BW-1:0]    s_be_q, s_be_d;

  logic [NUM_M-1:0] arb_gnt;
  logic [PW-1:0]    arb_idx;
  logic             arb_advance;

  logic [SLW-1:0]   sel;
  logic             dec_err;
  logic [DW-1:0]    rdata_mux;

  rr_arbiter #(.N(NUM_M)) u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (m_req),
    .advance (arb_advance),
    .gnt     (arb_gnt),
    .idx     (arb_idx)
  );

  assign sel     = addr_q[AW-1:SEL_LSB];
  assign dec_err = (int'(sel) >= NUM_S);

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    merr_d      = 1'b0;
    s_req_d     = '0;
    s_we_d      = 1'b0;
    s_addr_d    = '0;
    s_wdata_d   = '0;
    s_be_d      = '0;
    arb_advance = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|m_req) begin
          arb_advance = 1'b1;
          win_d       = arb_idx;
          gnt_d       = arb_gnt;
          for (int i = 0; i < NUM_M; i++) begin
            if (arb_gnt[i]) begin
              we_d    = m_we[i];
              addr_d  = m_addr[i*AW +: AW];
              wdata_d = m_wdata[i*DW +: DW];
              be_d    = m_be[i*BW +: BW];
            end
          end
          state_d = ST_ADDR;
        end
      end

      // Slave strobes are registered, so they are seen for exactly one cycle.
      ST_ADDR: begin
        if (!dec_err) begin
          for (int j = 0; j < NUM_S; j++) begin
            if (sel == SLW'(j)) s_req_d[j] = 1'b1;
          end
          s_we_d    = we_q;
          s_addr_d  = addr_q;
          s_wdata_d = wdata_q;
          s_be_d    = be_q;
        end
        state_d = ST_RESP;
      end

      ST_RESP: begin
        for (int i = 0; i < NUM_M; i++) begin
          if (win_q == PW'(i)) rvalid_d[i] = 1'b1;
        end
        merr_d  = dec_err;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Slave data arrives the cycle after s_req, which is the rvalid cycle;
  // the captured request is still held then, so it steers the mux.
  always_comb begin
    rdata_mux = '0;
    for (int j = 0; j < NUM_S; j++) begin
      if (sel == SLW'(j)) rdata_mux = s_rdata[j*DW +: DW];
    end
    m_rdata = '0;
    if (|rvalid_q) begin
      if (merr_q)     m_rdata = ERR_DATA;
      else if (!we_q) m_rdata = rdata_mux;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      win_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      gnt_q     <= '0;
      rvalid_q  <= '0;
      merr_q    <= 1'b0;
      s_req_q   <= '0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_be_q    <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      gnt_q     <= gnt_d;
      rvalid_q  <= rvalid_d;
      merr_q    <= merr_d;
      s_req_q   <= s_req_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_be_q    <= s_be_d;
    end
  end

  assign m_gnt    = gnt_q;
  assign m_rvalid = rvalid_q;
  assign m_err    = merr_q;
  assign s_req    = s_req_q;
  assign s_we     = s_we_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_be     = s_be_q;

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Directed bench for soc_bus_arbiter with a synchronous-memory slave model.
module tb_soc_bus_arbiter;

  localparam int NM = 2;
  localparam int NS = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BW = DW / 8;

  localparam logic [DW-1:0] ROM_VAL  = 32'h0B00_7001;
  localparam logic [DW-1:0] RAM_VAL  = 32'hCAFE_F00D;
  localparam logic [DW-1:0] PERI_VAL = 32'h5A5A_A5A5;

  logic              clk;
  logic              rstn;
  logic [NM-1:0]     m_req;
  logic [NM-1:0]     m_we;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_wdata;
  logic [NM*BW-1:0]  m_be;
  logic [NM-1:0]     m_gnt;
  logic [NM-1:0]     m_rvalid;
  logic [DW-1:0]     m_rdata;
  logic              m_err;
  logic [NS-1:0]     s_req;
  logic              s_we;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [BW-1:0]     s_be;
  logic [NS*DW-1:0]  s_rdata;

  logic [DW-1:0]     srd0, srd1, srd2;

  int checks = 0;
  int errors = 0;

  soc_bus_arbiter dut (
    .clk      (clk),
    .rstn     (rstn),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_be     (m_be),
    .m_gnt    (m_gnt),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata),
    .m_err    (m_err),
    .s_req    (s_req),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_be     (s_be),
    .s_rdata  (s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slaves answer the cycle after they see s_req.
  always @(posedge clk) begin
    if (s_req[0]) srd0 <= ROM_VAL;
    if (s_req[1]) srd1 <= RAM_VAL;
    if (s_req[2]) srd2 <= PERI_VAL;
  end
  assign s_rdata = {srd2, srd1, srd0};

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  int           gcyc [4];
  logic [NM-1:0] gval [4];
  int           ng;
  logic [NM-1:0] exp_g;

  initial begin
    srd0 = '0; srd1 = '0; srd2 = '0;
    rstn = 1'b0; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_be = '0;
    repeat (2) tick();
    check("rst_ctrl", {m_gnt, m_rvalid, m_err, s_req, s_we}, '0);
    check("rst_data", {m_rdata, s_addr}, '0);
    check("rst_wdata", {s_wdata, s_be}, '0);
    rstn = 1'b1;
    tick();

    // single read, m0 -> RAM
    m_we = 2'b00; m_addr[31:0] = 32'h1000_0010; m_be[3:0] = 4'hF; m_req = 2'b01;
    tick();
    check("rd_gnt", m_gnt, 2'b01);
    check("rd_gnt_rv", m_rvalid, 2'b00);
    m_req = 2'b00;
    tick();
    check("rd_sreq", s_req, 3'b010);
    check("rd_saddr", s_addr, 32'h1000_0010);
    check("rd_swe", s_we, 1'b0);
    check("rd_gnt_off", m_gnt, 2'b00);
    tick();
    check("rd_rvalid", m_rvalid, 2'b01);
    check("rd_rdata", m_rdata, RAM_VAL);
    check("rd_err", m_err, 1'b0);
    check("rd_sreq_off", s_req, 3'b000);
    tick();
    check("rd_rv_off", m_rvalid, 2'b00);

    // write, m1 -> peripherals
    m_we = 2'b10; m_addr[63:32] = 32'h2000_0004; m_wdata[63:32] = 32'h1234_5678;
    m_be[7:4] = 4'b0011; m_req = 2'b10;
    tick();
    check("wr_gnt", m_gnt, 2'b10);
    m_req = 2'b00;
    tick();
    check("wr_sreq", s_req, 3'b100);
    check("wr_swe", s_we, 1'b1);
    check("wr_sbe", s_be, 4'b0011);
    check("wr_swdata", s_wdata, 32'h1234_5678);
    check("wr_saddr", s_addr, 32'h2000_0004);
    tick();
    check("wr_sreq_off", {s_req, s_we}, '0);
    check("wr_rvalid", m_rvalid, 2'b10);
    check("wr_rdata", m_rdata, 32'h0);
    check("wr_err", m_err, 1'b0);
    tick();

    // contention: both masters request continuously
    m_we = 2'b00; m_addr[31:0] = 32'h1000_0000; m_addr[63:32] = 32'h0000_0100;
    for (int k = 0; k < 4; k++) begin gcyc[k] = 0; gval[k] = '0; end
    ng = 0;
    m_req = 2'b11;
    for (int c = 1; c <= 14 && ng < 4; c++) begin
      tick();
      if (m_gnt != '0) begin
        gval[ng] = m_gnt;
        gcyc[ng] = c;
        ng++;
        if (ng == 4) m_req = 2'b00;
      end
    end
    m_req = 2'b00;
    check("cont_count", ng, 4);
    check("cont_first_cyc", gcyc[0], 1);
    for (int k = 0; k < 4; k++) begin
`ifdef BUS_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
`endif
      check($sformatf("cont_gnt%0d", k), gval[k], exp_g);
      if (k > 0) check($sformatf("cont_gap%0d", k), gcyc[k] - gcyc[k-1], 3);
    end
    repeat (3) tick();

    // decode error, m0 reads unmapped slave index 5
    m_we = 2'b00; m_addr[31:0] = 32'h5000_0000; m_req = 2'b01;
    tick();
    check("de_gnt", m_gnt, 2'b01);
    m_req = 2'b00;
    tick();
    check("de_sreq", s_req, 3'b000);
    tick();
    check("de_rvalid", m_rvalid, 2'b01);
    check("de_err", m_err, 1'b1);
    check("de_rdata", m_rdata, 32'h0);
    tick();
    check("de_err_off", {m_rvalid, m_err}, '0);

    // late request: m1 arrives during m0's ADDR
    m_addr[31:0] = 32'h1000_0010; m_req = 2'b01;
    tick();
    check("late_gnt0", m_gnt, 2'b01);
    m_addr[63:32] = 32'h0000_0100; m_req = 2'b10;
    tick();
    check("late_no_gnt_resp", m_gnt, 2'b00);
    tick();
    check("late_no_gnt_idle", m_gnt, 2'b00);
    check("late_rv0", m_rvalid, 2'b01);
    check("late_rd0", m_rdata, RAM_VAL);
    tick();
    check("late_gnt1", m_gnt, 2'b10);
    m_req = 2'b00;
    tick();
    check("late_sreq", s_req, 3'b001);
    check("late_saddr", s_addr, 32'h0000_0100);
    tick();
    check("late_rv1", m_rvalid, 2'b10);
    check("late_rd1", m_rdata, ROM_VAL);
    tick();

    // reset during RESP aborts the transaction
    m_addr[31:0] = 32'h1000_0010; m_req = 2'b01;
    tick();
    check("mrst_gnt", m_gnt, 2'b01);
    m_req = 2'b00;
    tick();
    check("mrst_sreq", s_req, 3'b010);
    rstn = 1'b0;
    #1;
    check("mrst_ctrl", {m_gnt, m_rvalid, m_err, s_req, s_we}, '0);
    check("mrst_data", {m_rdata, s_addr}, '0);
    check("mrst_wdata", {s_wdata, s_be}, '0);
    tick();
    check("mrst_no_rv", m_rvalid, 2'b00);
    rstn = 1'b1;
    tick();
    check("post_rst_idle", {m_gnt, m_rvalid}, '0);
    tick();
    check("post_rst_idle2", {m_gnt, m_rvalid}, '0);
    m_addr[63:32] = 32'h0000_0100; m_req = 2'b11;
    tick();
    check("post_rst_gnt", m_gnt, 2'b01);
    m_req = 2'b00;
    tick();
    check("post_rst_sreq", s_req, 3'b010);
    tick();
    check("post_rst_rv", m_rvalid, 2'b01);
    check("post_rst_rd", m_rdata, RAM_VAL);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_bus_arbiter.md
Name: soc_bus_arbiter

Overview:
- Parametrised N-master/M-slave shared memory bus; the next generation of the fixed SoC data-path wiring.
- Replaces point-to-point core→ram / jtag→rom hookups: core data port, JTAG debug master, and future DMA arbitrate for ROM, RAM, and peripheral slaves.
- Address-decoded slave select, round-robin arbitration, one outstanding transaction, registered response.
- Slaves are synchronous memories: read data valid the cycle after request.

Parameters:
NUM_M, 2, number of masters (index 0 = core, 1 = JTAG)
NUM_S, 3, number of slaves (0 = ROM, 1 = RAM, 2 = peripherals)
DW, 32, data width
AW, 32, address width
SEL_LSB, 28, slave index = addr[AW-1:SEL_LSB]
ERR_DATA, 32'h0, read data returned on decode error

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
m_req  in  NUM_M  master request, held until m_gnt
m_we  in  NUM_M  1 = write, 0 = read
m_addr  in  NUM_M*AW  per-master address, packed, master i at [i*AW +: AW]
m_wdata  in  NUM_M*DW  per-master write data
m_be  in  NUM_M*DW/8  per-master byte enables
m_gnt  out  NUM_M  one-hot grant, 1-cycle pulse
m_rvalid  out  NUM_M  one-hot response pulse (read data or write ack)
m_rdata  out  DW  response data, shared, qualified by m_rvalid
m_err  out  1  decode error, qualified by m_rvalid
s_req  out  NUM_S  one-hot slave request
s_we  out  1  write strobe to selected slave
s_addr  out  AW  shared slave address
s_wdata  out  DW  shared write data
s_be  out  DW/8  shared byte enables
s_rdata  in  NUM_S*DW  per-slave read data, valid 1 cycle after s_req

Behaviour:
- Reset: state=IDLE, rr pointer=0; m_gnt, m_rvalid, m_err, s_req, s_we = 0; m_rdata, s_addr, s_wdata, s_be = 0.
- Reset asserted mid-transaction aborts it. No response is issued. Masters must re-request.
- FSM IDLE→ADDR→RESP→IDLE:
  - IDLE: if any m_req, choose winner w, register its we/addr/wdata/be and w, pulse m_gnt[w], go ADDR. Otherwise stay.
  - ADDR: decode idx=addr[AW-1:SEL_LSB].
    - idx<NUM_S: drive s_req[idx]=1, s_we, s_addr, s_wdata, s_be from the registered copy for exactly one cycle.
    - idx≥NUM_S: no s_req; flag error.
    - Go RESP.
  - RESP: pulse m_rvalid[w] for one cycle.
    - m_rdata = s_rdata[idx] for a read, ERR_DATA on error, 0 for a write.
    - m_err = error flag.
    - Go IDLE.
- Latency: m_req to m_gnt is 1 cycle. m_gnt to m_rvalid is 2 cycles. Peak throughput is one transaction per 3 cycles.
- Round-robin: search starts at rr pointer. After a grant, pointer = w+1 mod NUM_M.
- A master whose m_req is low when searched is skipped. m_req deasserting before grant drops that request silently.
- A request arriving during ADDR/RESP waits. Simultaneous requests are resolved solely by the pointer.
- Write ack: m_rvalid with m_rdata=0, m_err=0. A write to a decode-error address is dropped and m_err=1.
- s_* outputs return to 0 outside ADDR. Slaves must not see a stale s_we.
- Widths: NUM_M and NUM_S between 1 and 16. Pointer width is clog2(NUM_M), minimum 1.

Optional Feature:
- Macro BUS_FIXED_PRIO_EN.
- Defined: fixed priority, lowest master index wins; rr pointer logic is removed.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Decomposition:
- Shared package bus_pkg:
  - FSM state encoding (IDLE/ADDR/RESP)
  - default DW/AW
  - byte-enable width function DW/8
  - clog2 helper
- Sub-module rr_arbiter:
  - Parameter N; inputs req[N], advance; output one-hot gnt[N] and index.
  - Holds the pointer.
  - Under BUS_FIXED_PRIO_EN it reduces to a priority encoder.

Test Plan:
- Reset: rstn=0 during RESP → all outputs 0 next cycle; after release, first request granted with no stale m_rvalid.
- Single read: m0 reads 0x1000_0010, RAM returns 0xCAFE_F00D → m_gnt[0] at T+1, s_req=3'b010 and s_addr=0x1000_0010 at T+2, m_rvalid[0] with m_rdata=0xCAFE_F00D and m_err=0 at T+3.
- Write: m1 writes 0x2000_0004, wdata 0x1234_5678, be 4'b0011 → s_req=3'b100, s_we=1, s_be=4'b0011 for exactly one cycle; m_rvalid[1] pulse with m_rdata=0.
- Contention: m0 and m1 request continuously → grants alternate 0,1,0,1 every 3 cycles. With BUS_FIXED_PRIO_EN, m0 is granted every time.
- Decode error: m0 reads 0x5000_0000 → no s_req, m_rvalid[0]=1, m_err=1, m_rdata=ERR_DATA.
- Late request: m1 raises m_req during m0's ADDR → m1 granted in the cycle after m0's RESP returns to IDLE, never during ADDR/RESP.
